pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use hazards, taken branches resolved in MEM, and jumps decoded in ID. Freezes the pipeline while a multi-cycle data-memory access is outstanding. Drives the write-enable, flush and PC-select controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps hazard performance counters.

Parameters:
COUNT_W, 16, width of the saturating performance counters
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before MemError is raised (>=1)

Ports:
Clk  in  1  pipeline clock, rising edge
Reset  in  1  synchronous, active-high
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rt  in  5  load destination register in EX
IFID_Rs  in  5  rs of instruction in ID
IFID_Rt  in  5  rt of instruction in ID
IFID_UsesRt  in  1  ID instruction reads rt (R-type, sw, beq/bne)
ID_Jump  in  1  ID instruction is j/jal/jr
EXMEM_Branch  in  1  MEM-stage instruction is a branch
EXMEM_Taken  in  1  branch condition true (from EX/MEM zero/compare)
DMemReq  in  1  MEM-stage access (MemRead|MemWrite)
DMemReady  in  1  data memory completes access this cycle
PCWrite  out  1  PC load enable
IFID_Write  out  1  IF/ID load enable
IFID_Flush  out  1  IF/ID loads NOP
IDEX_Write  out  1  ID/EX load enable
IDEX_Bubble  out  1  ID/EX loads zeroed controls
EXMEM_Write  out  1  EX/MEM load enable
EXMEM_Flush  out  1  EX/MEM loads zeroed controls
MEMWB_Bubble  out  1  MEM/WB loads zeroed controls
PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target
StallCycles  out  COUNT_W  cycles with PCWrite=0 (saturating)
FlushEvents  out  COUNT_W  taken branches + jumps acted on (saturating)
MemError  out  1  sticky MEM_TIMEOUT flag

Behaviour:
- States: RUN, MEM_WAIT. Registered state; control outputs combinational from state and inputs; counters and MemError registered.
- Reset at clock edge: state=RUN, wait counter=0, StallCycles=0, FlushEvents=0, MemError=0. While Reset high: PCWrite=IFID_Write=IDEX_Write=EXMEM_Write=0; IFID_Flush=IDEX_Bubble=EXMEM_Flush=MEMWB_Bubble=1; PCSrc=0. Reset asserted mid-MEM_WAIT abandons the wait.
- Defaults (no event): all Write=1, all Flush/Bubble=0, PCSrc=0.
- Priority, highest first: memory wait > taken branch > load-use > jump.
- Memory wait: in RUN, DMemReq & !DMemReady -> freeze this cycle (PCWrite, IFID_Write, IDEX_Write, EXMEM_Write=0; MEMWB_Bubble=1) and go to MEM_WAIT with wait counter=1. In MEM_WAIT: if !DMemReady, freeze and increment the counter. If DMemReady, release with default outputs, go to RUN and clear the counter. A single-cycle access (DMemReady high on the request cycle) never leaves RUN.
- Timeout: when the wait counter reaches MEM_TIMEOUT, set MemError (sticky until Reset). The FSM stays in MEM_WAIT, frozen.
- Taken branch (RUN, EXMEM_Branch & EXMEM_Taken, no memory wait): PCSrc=1; IFID_Flush, IDEX_Bubble, EXMEM_Flush=1. The 3-cycle penalty is applied in one cycle. Load-use and jump are ignored that cycle.
- Load-use: IDEX_MemRead & IDEX_Rt!=0 & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)) -> PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle. The bubble clears IDEX_MemRead, so the stall self-terminates. ID_Jump is suppressed that cycle and re-evaluated next cycle.
- Jump (RUN, no higher event): PCSrc=2, IFID_Flush=1 (1-cycle penalty).
- If a taken branch coincides with a memory wait, the freeze wins. EX/MEM is held, so the branch is acted on the cycle DMemReady releases.
- StallCycles increments each non-reset cycle with PCWrite=0. FlushEvents increments on each branch/jump redirect. Both saturate at all-ones, no wrap.

Test Plan:
- Reset held 2 cycles, then release with idle inputs -> all Write=1, Flush/Bubble=0, PCSrc=0, counters 0, MemError=0.
- lw $5 in EX (IDEX_MemRead=1, IDEX_Rt=5), add in ID with Rs=5 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1, StallCycles=1. Same with IDEX_Rt=0 -> no stall.
- EXMEM_Branch=1, EXMEM_Taken=1 with a simultaneous load-use -> PCSrc=1, three flushes, no stall, FlushEvents=1.
- DMemReq=1, DMemReady low 3 cycles then high -> 3 frozen cycles with MEMWB_Bubble=1, release on the 4th, StallCycles=3, state RUN.
- MEM_TIMEOUT=4, DMemReady never asserted -> MemError=1 after the 4th wait cycle, pipeline stays frozen. Reset clears MemError.
- ID_Jump=1 with no other event -> PCSrc=2, IFID_Flush=1. Force counter to all-ones -> further events hold the value.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/PC-select sequencer for a 5-stage MIPS pipeline.
// Priority is memory wait > taken branch > load-use > jump. Counters and MemError are registered.
module pipeline_hazard_controller #(
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               IDEX_MemRead,
    input  logic [4:0]         IDEX_Rt,
    input  logic [4:0]         IFID_Rs,
    input  logic [4:0]         IFID_Rt,
    input  logic               IFID_UsesRt,
    input  logic               ID_Jump,
    input  logic               EXMEM_Branch,
    input  logic               EXMEM_Taken,
    input  logic               DMemReq,
    input  logic               DMemReady,
    output logic               PCWrite,
    output logic               IFID_Write,
    output logic               IFID_Flush,
    output logic               IDEX_Write,
    output logic               IDEX_Bubble,
    output logic               EXMEM_Write,
    output logic               EXMEM_Flush,
    output logic               MEMWB_Bubble,
    output logic [1:0]         PCSrc,
    output logic [COUNT_W-1:0] StallCycles,
    output logic [COUNT_W-1:0] FlushEvents,
    output logic               MemError
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t        state;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          freeze, branch, load_use, jump;
    always_comb begin
        freeze   = (state == RUN) ? (DMemReq & ~DMemReady) : ~DMemReady;
        branch   = ~freeze & EXMEM_Branch & EXMEM_Taken;
        load_use = ~freeze & ~branch & IDEX_MemRead & (IDEX_Rt != 5'd0) &
                   ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
        jump     = ~freeze & ~branch & ~load_use & ID_Jump;
        PCWrite      = ~Reset & ~freeze & ~load_use;
        IFID_Write   = ~Reset & ~freeze & ~load_use;
        IFID_Flush   = Reset | branch | jump;
        IDEX_Write   = ~Reset & ~freeze;
        IDEX_Bubble  = Reset | branch | load_use;
        EXMEM_Write  = ~Reset & ~freeze;
        EXMEM_Flush  = Reset | branch;
        MEMWB_Bubble = Reset | freeze;
        PCSrc        = Reset ? 2'd0 : branch ? 2'd1 : jump ? 2'd2 : 2'd0;
        // The wait counter parks at MEM_TIMEOUT so it cannot wrap while stuck.
        wait_nxt = !freeze ? '0 :
                   (state == RUN) ? CW'(1) :
                   (wait_cnt == CW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + CW'(1);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            StallCycles <= '0;
            FlushEvents <= '0;
            MemError    <= 1'b0;
        end else begin
            state    <= freeze ? MEM_WAIT : RUN;
            wait_cnt <= wait_nxt;
            MemError <= MemError | (freeze & (wait_nxt == CW'(MEM_TIMEOUT)));
            if (!PCWrite && StallCycles != '1)
                StallCycles <= StallCycles + COUNT_W'(1);
            if ((branch | jump) && FlushEvents != '1)
                FlushEvents <= FlushEvents + COUNT_W'(1);
        end
    end
endmodule
